// File: rtl/ahb2apb_bridge_multi_if.sv
// ----------------------------------------------------------------------------
// ahb2apb_bridge_multi_if
// Purpose : groups the AHB-Lite slave side and the APB3 master side of the
//           multi-slave bridge into one bundle.
// Ports   : AHB  - iHSEL, iHADDR, iHTRANS, iHWRITE, iHSIZE, iHWDATA (to bridge)
//                  oHRDATA, oHREADY, oHRESP (from bridge)
//           APB  - oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA (from bridge)
//                  iPRDATA, iPREADY, iPSLVERR (to bridge, one slice per slave)
// Modports: slave  - the bridge's view (AHB slave / APB master)
//           master - the view of whatever drives the AHB side and models the
//                    APB peripherals
// ----------------------------------------------------------------------------
interface ahb2apb_bridge_multi_if #(
    parameter int NSLV   = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                     iHSEL;
    logic [ADDR_W-1:0]        iHADDR;
    logic [1:0]               iHTRANS;
    logic                     iHWRITE;
    logic [2:0]               iHSIZE;
    logic [DATA_W-1:0]        iHWDATA;
    logic [DATA_W-1:0]        oHRDATA;
    logic                     oHREADY;
    logic [1:0]               oHRESP;

    logic [NSLV-1:0]          oPSEL;
    logic                     oPENABLE;
    logic                     oPWRITE;
    logic [ADDR_W-1:0]        oPADDR;
    logic [DATA_W-1:0]        oPWDATA;
    logic [NSLV*DATA_W-1:0]   iPRDATA;
    logic [NSLV-1:0]          iPREADY;
    logic [NSLV-1:0]          iPSLVERR;

    modport slave (
        input  iHSEL, iHADDR, iHTRANS, iHWRITE, iHSIZE, iHWDATA,
        output oHRDATA, oHREADY, oHRESP,
        output oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA,
        input  iPRDATA, iPREADY, iPSLVERR
    );

    modport master (
        output iHSEL, iHADDR, iHTRANS, iHWRITE, iHSIZE, iHWDATA,
        input  oHRDATA, oHREADY, oHRESP,
        input  oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA,
        output iPRDATA, iPREADY, iPSLVERR
    );
endinterface

// File: rtl/ahb2apb_bridge_multi.sv
// ----------------------------------------------------------------------------
// ahb2apb_bridge_multi
// Purpose : AHB-Lite slave to APB3 master bridge serving NSLV peripherals.
//           Each AHB transfer is decoded to one slave by 4 KB address window
//           and run as an APB SETUP/ACCESS sequence. PREADY stretches the AHB
//           transfer; PSLVERR, a wait timeout or an unmapped address produce a
//           two-cycle AHB ERROR response.
// Ports   : iHCLK    - clock, rising edge
//           iHRESETn - synchronous reset, active low
//           bus      - ahb2apb_bridge_multi_if.slave (AHB + APB signals)
// ----------------------------------------------------------------------------
module ahb2apb_bridge_multi #(
    parameter int NSLV    = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int WIN_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                         iHCLK,
    input  logic                         iHRESETn,
    ahb2apb_bridge_multi_if.slave        bus
);

    localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WCAP,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_waitCnt;

    logic               w_request;
    logic [ADDR_W-1:0]  w_idxFull;
    logic               w_idxValid;
    logic [NSLV-1:0]    w_newSel;
    logic [NSLV-1:0]    w_regSel;
    logic               w_selReady;
    logic               w_selErr;
    logic [DATA_W-1:0]  w_selData;
    logic               w_unusedHsize;

    // Address decode works on the full shifted address so that any window
    // beyond the last slave is flagged, not aliased onto a real peripheral.
    assign w_request     = bus.iHSEL & bus.iHTRANS[1];
    assign w_idxFull     = bus.iHADDR >> WIN_LSB;
    assign w_idxValid    = (w_idxFull < ADDR_W'(NSLV));
    assign w_newSel      = NSLV'(1) << w_idxFull[IDX_W-1:0];
    assign w_regSel      = NSLV'(1) << r_idx;

    // Only the addressed slave's handshake and data are ever looked at.
    assign w_selReady    = bus.iPREADY[r_idx];
    assign w_selErr      = bus.iPSLVERR[r_idx];
    assign w_selData     = bus.iPRDATA[r_idx*DATA_W +: DATA_W];

    // APB3 has no size signal, so HSIZE is accepted and dropped.
    assign w_unusedHsize = ^bus.iHSIZE;

    // Bridge FSM with all outputs registered. PSEL goes high on the edge that
    // enters SETUP, so the APB setup phase is the first cycle after the
    // address is known (reads) or after write data is captured (writes).
    always_ff @(posedge iHCLK) begin
        if (!iHRESETn) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_waitCnt    <= '0;
            bus.oHREADY  <= 1'b1;
            bus.oHRESP   <= 2'b00;
            bus.oHRDATA  <= '0;
            bus.oPSEL    <= '0;
            bus.oPENABLE <= 1'b0;
            bus.oPWRITE  <= 1'b0;
            bus.oPADDR   <= '0;
            bus.oPWDATA  <= '0;
        end else begin
            case (r_state)
                IDLE, ERR2: begin
                    r_state     <= IDLE;
                    bus.oHREADY <= 1'b1;
                    bus.oHRESP  <= 2'b00;
                    if (w_request) begin
                        bus.oHREADY <= 1'b0;
                        if (!w_idxValid) begin
                            // Unmapped window: error without touching APB.
                            r_state    <= ERR1;
                            bus.oHRESP <= 2'b01;
                        end else begin
                            r_idx       <= w_idxFull[IDX_W-1:0];
                            bus.oPADDR  <= bus.iHADDR;
                            bus.oPWRITE <= bus.iHWRITE;
                            if (bus.iHWRITE) begin
                                r_state <= WCAP;
                            end else begin
                                r_state   <= SETUP;
                                bus.oPSEL <= w_newSel;
                            end
                        end
                    end
                end
                WCAP: begin
                    bus.oPWDATA <= bus.iHWDATA;
                    bus.oPSEL   <= w_regSel;
                    r_state     <= SETUP;
                end
                SETUP: begin
                    bus.oPENABLE <= 1'b1;
                    r_waitCnt    <= '0;
                    r_state      <= ACCESS;
                end
                ACCESS: begin
                    if (w_selReady) begin
                        bus.oPSEL    <= '0;
                        bus.oPENABLE <= 1'b0;
                        if (w_selErr) begin
                            if (!bus.oPWRITE) begin
                                bus.oHRDATA <= '0;
                            end
                            bus.oHRESP <= 2'b01;
                            r_state    <= ERR1;
                        end else begin
                            if (!bus.oPWRITE) begin
                                bus.oHRDATA <= w_selData;
                            end
                            bus.oHREADY <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end else if ((TIMEOUT > 0) && (r_waitCnt == CNT_LAST)) begin
                        // Slave never answered: abandon the access.
                        bus.oPSEL    <= '0;
                        bus.oPENABLE <= 1'b0;
                        bus.oHRESP   <= 2'b01;
                        r_state      <= ERR1;
                    end else begin
                        r_waitCnt <= r_waitCnt + CNT_W'(1);
                    end
                end
                ERR1: begin
                    // Second half of the AHB error response: HREADY rises
                    // while HRESP stays ERROR.
                    bus.oHREADY <= 1'b1;
                    r_state     <= ERR2;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
